// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

   // Default operand width.
   localparam int unsigned MUL_N_DEF = 8;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   // Width of a counter that must hold values 0..n.
   function automatic int unsigned CNT_W(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage : mul_pkg

// File: rtl/add_n.sv
// N-bit ripple-carry adder with a registered carry-in for chained multi-word adds.
module add_n #(
   parameter int unsigned N = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         cin_we_i,
   input  logic         cin_d_i,
   input  logic [N-1:0] data0_i,
   input  logic [N-1:0] data1_i,
   output logic [N-1:0] sum_o,
   output logic         over_o
);

   logic         r_cin;
   logic [N:0]   w_c;
   logic [N-1:0] w_sum;

   // Carry-in register; left at zero when the write enable is never asserted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cin <= 1'b0;
      end else if (cin_we_i) begin
         r_cin <= cin_d_i;
      end
   end

   // Ripple chain of full adders.
   always_comb begin
      w_c    = '0;
      w_sum  = '0;
      w_c[0] = r_cin;
      for (int unsigned i = 0; i < N; i++) begin
         w_sum[i]  = data0_i[i] ^ data1_i[i] ^ w_c[i];
         w_c[i+1]  = (data0_i[i] & data1_i[i]) | (w_c[i] & (data0_i[i] ^ data1_i[i]));
      end
   end

   assign sum_o  = w_sum;
   assign over_o = w_c[N];

endmodule : add_n

// File: rtl/mul_seq_n.sv
// Sequential unsigned shift-add multiplier: N-bit x N-bit -> 2N-bit, one adder pass per multiplier bit.
module mul_seq_n
   import mul_pkg::*;
#(
   parameter int unsigned N = MUL_N_DEF
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           start_i,
   input  logic [N-1:0]   a_i,
   input  logic [N-1:0]   b_i,
   output logic           busy_o,
   output logic           valid_o,
   input  logic           ready_i,
   output logic [2*N-1:0] prod_o
);

   localparam int unsigned CW = CNT_W(N);
   localparam int unsigned PW = 2 * N;

   mul_state_t      r_state;
   mul_state_t      w_state_nxt;
   logic [N-1:0]    r_mcand;
   logic [N-1:0]    w_mcand_nxt;
   logic [PW-1:0]   r_p;
   logic [PW-1:0]   w_p_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;

   logic [N-1:0]    w_addend;
   logic [N-1:0]    w_sum;
   logic            w_over;
   logic [PW:0]     w_shift;
   logic            w_last;

   // Partial-product adder; its carry-in register is never written so it stays zero.
   add_n #(
      .N (N)
   ) u_add (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .cin_we_i (1'b0),
      .cin_d_i  (1'b0),
      .data0_i  (r_p[PW-1:N]),
      .data1_i  (w_addend),
      .sum_o    (w_sum),
      .over_o   (w_over)
   );

   // Add the multiplicand only when the current multiplier LSB is set.
   assign w_addend = r_p[0] ? r_mcand : '0;

   // Carry-out becomes the new MSB after the right shift, so the full 2N+1 bits are kept.
   assign w_shift  = {w_over, w_sum, r_p[N-1:0]};
   assign w_last   = (r_cnt == CW'(N - 1));

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_mcand <= '0;
         r_p     <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_mcand <= w_mcand_nxt;
         r_p     <= w_p_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      w_state_nxt = r_state;
      w_mcand_nxt = r_mcand;
      w_p_nxt     = r_p;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (start_i) begin
               w_mcand_nxt = a_i;
               w_p_nxt     = {N'(0), b_i};
               w_cnt_nxt   = '0;
               w_state_nxt = CALC;
            end
         end
         CALC: begin
            w_p_nxt   = w_shift[PW:1];
            w_cnt_nxt = r_cnt + CW'(1);
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            // A start seen here is dropped; only the handshake completes.
            if (ready_i) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Status is decoded straight from the state register; product is the P register.
   assign busy_o  = (r_state == CALC);
   assign valid_o = (r_state == DONE);
   assign prod_o  = r_p;

endmodule : mul_seq_n
